in_port_conditioner: RTL

//   Conditions external switch/button lines before they reach the MY8CPU IN[7:0] port.
//   - Per bit: 2-flop synchroniser, then counter debounce.
//   - Outputs a stable level vector for the CPU's IN port.
//   - Emits one-cycle rising-edge pulses.
//   - Optionally latches rising edges until the CPU clears them.
//   - Sits between the board pins and MY8CPU.IN, on the CPU clock domain.

---
 rtl/in_port_conditioner_if.sv | 27 ++
 rtl/in_port_conditioner.sv | 87 ++++++++
 2 files changed

// File: rtl/in_port_conditioner_if.sv
// Input-port bus between board pins / CPU and the conditioner.
// master: pins+CPU side (raw_in, evt_clr); slave: conditioner side.
interface in_port_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] evt_clr;
  logic [WIDTH-1:0] in_stable;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] evt_latch;

  modport master (
    output raw_in,
    output evt_clr,
    input  in_stable,
    input  rise_pulse,
    input  evt_latch
  );

  modport slave (
    input  raw_in,
    input  evt_clr,
    output in_stable,
    output rise_pulse,
    output evt_latch
  );
endinterface

// File: rtl/in_port_conditioner.sv
// Per-bit 2-flop sync + counter debounce for MY8CPU IN port; rise pulses.
// Ports: clock_in, nReset, port (raw_in,evt_clr -> in_stable,rise_pulse,evt_latch); macro IN_PORT_EDGE_LATCH_EN.
module in_port_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input logic                 clock_in,
  input logic                 nReset,
  in_port_conditioner_if.slave port
);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] rise_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];

  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_d;
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      unique case (1'b1)
        (sync2[i] == stable_q[i]): begin
          cnt_d[i] = '0;
        end
        (sync2[i] != stable_q[i]) &&
        (cnt_q[i] == LAST): begin
          stable_d[i] = sync2[i];
          rise_d[i]   = sync2[i];
        end
        default: begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1    <= port.raw_in;
      sync2    <= sync1;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign port.in_stable  = stable_q;
  assign port.rise_pulse = rise_q;

`ifdef IN_PORT_EDGE_LATCH_EN
  logic [WIDTH-1:0] latch_q;

  // set uses the same-edge rise so a set beats a simultaneous clear
  always_ff @(posedge clock_in or negedge nReset) begin
    if (!nReset) begin
      latch_q <= '0;
    end else begin
      latch_q <= (latch_q & ~port.evt_clr) | rise_d;
    end
  end

  assign port.evt_latch = latch_q;
`else
  logic unused_clr;
  assign unused_clr     = ^port.evt_clr;
  assign port.evt_latch = '0;
`endif
endmodule
